if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// ============================================================================
//  Module      : if_stage
//  Description : Instruction fetch stage. Issues one word-aligned fetch at a
//                time to instruction memory and presents the returned word
//                to ID through a single output slot backed by a one-entry
//                hold buffer. Redirects flush the slot and any in-flight
//                response.
//                Optional macro FETCH_CNT_EN adds a delivered-instruction
//                counter output (fetch_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        outside_reset,
   input  logic        stall_id,
   input  logic        redirect_vld,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        VALID_ID,
   output logic [31:0] PC_ID,
   output logic [31:0] INSTRUCTION_ID
`ifdef FETCH_CNT_EN
   ,
   output logic [31:0] fetch_cnt
`endif
);

   localparam logic [1:0]  c_st_boot = 2'd0;
   localparam logic [1:0]  c_st_req  = 2'd1;
   localparam logic [1:0]  c_st_wait = 2'd2;
   localparam logic [1:0]  c_st_hold = 2'd3;
   localparam logic [31:0] c_nop     = 32'h0000_0013;
   localparam logic [31:0] c_align   = 32'hFFFF_FFFC;

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic        r_drop;
   logic        w_drop_nxt;
   logic [31:0] r_fetch_pc;
   logic        r_valid;
   logic [31:0] r_pc_id;
   logic [31:0] r_instr_id;
   logic [31:0] r_hold_pc;
   logic [31:0] r_hold_instr;

   logic [31:0] w_redirect_pc;
   logic        w_slot_free;
   logic        w_accept;
   logic        w_deliver;
   logic        w_to_hold;
   logic        w_release;

   // Low address bits of a redirect target are forced to zero.
   assign w_redirect_pc = redirect_pc & c_align;

   // The output slot can take new data when empty or when ID consumes it now.
   assign w_slot_free = !r_valid || !stall_id;

   // A response is kept only in WAIT, when not flagged stale and not flushed.
   assign w_accept  = (r_state == c_st_wait) && imem_rvalid && !r_drop && !redirect_vld;
   assign w_deliver = w_accept && w_slot_free;
   assign w_to_hold = w_accept && !w_slot_free;
   assign w_release = (r_state == c_st_hold) && !stall_id && !redirect_vld;

   // State and drop-flag register.
   always_ff @(posedge clk or posedge outside_reset) begin
      if (outside_reset) begin
         r_state <= c_st_boot;
         r_drop  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_drop  <= w_drop_nxt;
      end
   end

   // Next-state logic; a redirect while a request is in flight marks its response stale.
   always_comb begin
      w_state_nxt = r_state;
      w_drop_nxt  = r_drop;
      case (r_state)
         c_st_boot: w_state_nxt = c_st_req;
         c_st_req: begin
            if (imem_ack) begin
               w_state_nxt = c_st_wait;
               if (redirect_vld) w_drop_nxt = 1'b1;
            end
         end
         c_st_wait: begin
            if (imem_rvalid) begin
               // The response arriving now is consumed (kept or discarded), so the
               // flag never outlives it; a same-cycle redirect discards it directly.
               w_drop_nxt = 1'b0;
               if (r_drop || redirect_vld || w_slot_free) w_state_nxt = c_st_req;
               else                                       w_state_nxt = c_st_hold;
            end else if (redirect_vld) begin
               w_drop_nxt = 1'b1;
            end
         end
         c_st_hold: begin
            if (redirect_vld || !stall_id) w_state_nxt = c_st_req;
         end
         default: w_state_nxt = c_st_boot;
      endcase
   end

   // Memory request outputs: request only in REQ, address always tracks fetch_pc.
   always_comb begin
      imem_req  = (r_state == c_st_req);
      imem_addr = r_fetch_pc;
   end

   // Fetch PC: redirect wins, otherwise advance past each kept response.
   always_ff @(posedge clk or posedge outside_reset) begin
      if (outside_reset)     r_fetch_pc <= RESET_PC & c_align;
      else if (redirect_vld) r_fetch_pc <= w_redirect_pc;
      else if (w_accept)     r_fetch_pc <= r_fetch_pc + 32'd4;
   end

   // Output slot: flush on redirect, load from memory or hold buffer, drain when consumed.
   always_ff @(posedge clk or posedge outside_reset) begin
      if (outside_reset) begin
         r_valid    <= 1'b0;
         r_pc_id    <= 32'h0000_0000;
         r_instr_id <= c_nop;
      end else if (redirect_vld) begin
         r_valid <= 1'b0;
      end else if (w_deliver) begin
         r_valid    <= 1'b1;
         r_pc_id    <= r_fetch_pc;
         r_instr_id <= imem_rdata;
      end else if (w_release) begin
         r_valid    <= 1'b1;
         r_pc_id    <= r_hold_pc;
         r_instr_id <= r_hold_instr;
      end else if (!stall_id) begin
         r_valid <= 1'b0;
      end
   end

   // Hold buffer captures a response that arrives while ID is stalled; HOLD marks it full.
   always_ff @(posedge clk or posedge outside_reset) begin
      if (outside_reset) begin
         r_hold_pc    <= 32'h0000_0000;
         r_hold_instr <= c_nop;
      end else if (w_to_hold) begin
         r_hold_pc    <= r_fetch_pc;
         r_hold_instr <= imem_rdata;
      end
   end

   // ID-facing outputs; the instruction reads as NOP whenever the slot is empty.
   always_comb begin
      VALID_ID       = r_valid;
      PC_ID          = r_pc_id;
      INSTRUCTION_ID = r_valid ? r_instr_id : c_nop;
   end

`ifdef FETCH_CNT_EN
   logic [31:0] r_fetch_cnt;

   // Count instructions actually consumed by ID.
   always_ff @(posedge clk or posedge outside_reset) begin
      if (outside_reset)                          r_fetch_cnt <= 32'h0000_0000;
      else if (r_valid && !stall_id && !redirect_vld) r_fetch_cnt <= r_fetch_cnt + 32'd1;
   end

   assign fetch_cnt = r_fetch_cnt;
`endif

endmodule

`default_nettype wire
